// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared types and helpers for the 2D convolution window engine.
//               Holds the controller state encoding, the tap-count helper and
//               the saturating adder used by the MAC.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Number of multiply-accumulate taps in one window.
    function automatic int calc_taps(input int k, input int ch);
        return k * k * ch;
    endfunction

    // Adds two values that fit in w bits (w <= 64, passed sign-extended to
    // 64 bits) and clamps the sum to the signed w-bit range. The 65-bit sum
    // cannot overflow, so the clamp decision is exact.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int                 w);
        logic signed [64:0] s;
        logic signed [64:0] mx;
        logic signed [64:0] mn;
        s  = {a[63], a} + {b[63], b};
        mx = (65'sd1 <<< (w - 1)) - 65'sd1;
        mn = -(65'sd1 <<< (w - 1));
        if (s > mx)
            return 64'(mx);
        else if (s < mn)
            return 64'(mn);
        else
            return 64'(s);
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_mac.sv
`default_nettype none
// ============================================================================
// Module      : conv_mac
// Description : Signed multiply-accumulate slice. One product per enabled
//               cycle is added to the accumulator, either wrapping or
//               saturating depending on SAT.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               i_clr          - synchronous clear of the accumulator
//               i_en           - accumulate i_a*i_b this cycle
//               i_a, i_b       - signed operands
//               o_acc          - accumulator value
// Revision    : 1.0 - initial release
// ============================================================================
module conv_mac
    import conv_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int SAT    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    output logic signed [ACC_W-1:0]  o_acc
);

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_next;
    logic signed [ACC_W-1:0]    r_acc;

    assign w_prod     = i_a * i_b;
    assign w_prod_ext = ACC_W'(w_prod);

    generate
        if (SAT != 0) begin : g_sat
            assign w_next = ACC_W'(sat_add(64'(w_prod_ext), 64'(r_acc), ACC_W));
        end else begin : g_wrap
            assign w_next = w_prod_ext + r_acc;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_acc <= '0;
        else if (i_clr)
            r_acc <= '0;
        else if (i_en)
            r_acc <= w_next;
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/conv2d_window_engine.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_window_engine
// Description : Computes one output pixel as the signed dot product of a
//               K x K x CH kernel with the matching image window, reading
//               external synchronous memories (1-cycle latency).
// Ports       : start/relu_en/base_addr_k/base_addr_d - window request
//               k_addr/d_addr, k_data/d_data         - memory read ports
//               out_pix/out_valid/out_ack            - result handshake
//               busy, done                           - status
// Revision    : 1.0 - initial release
// ============================================================================
module conv2d_window_engine
    import conv_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 32,
    parameter int K       = 3,
    parameter int CH      = 1,
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int KADDR_W = 10,
    parameter int DADDR_W = 16,
    parameter int SAT     = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               relu_en,
    input  logic [KADDR_W-1:0] base_addr_k,
    input  logic [DADDR_W-1:0] base_addr_d,
    output logic [KADDR_W-1:0] k_addr,
    output logic [DADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0]  k_data,
    input  logic [DATA_W-1:0]  d_data,
    output logic [ACC_W-1:0]   out_pix,
    output logic               out_valid,
    input  logic               out_ack,
    output logic               busy,
    output logic               done
);

    localparam int c_KW = (K  > 1) ? $clog2(K)  : 1;
    localparam int c_CW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [c_KW-1:0]    c_KLAST = c_KW'(K - 1);
    localparam logic [c_CW-1:0]    c_CLAST = c_CW'(CH - 1);
    localparam logic [DADDR_W-1:0] c_ROW   = DADDR_W'(IMG_W);
    localparam logic [DADDR_W-1:0] c_PLANE = DADDR_W'(IMG_W * IMG_H);

    state_t r_state, w_next_state;

    logic [c_CW-1:0]    r_c;
    logic [c_KW-1:0]    r_r;
    logic [c_KW-1:0]    r_col;
    logic [KADDR_W-1:0] r_k_addr;
    logic [DADDR_W-1:0] r_d_addr;
    logic [DADDR_W-1:0] r_row_base;   // data address of (c, r, 0)
    logic [DADDR_W-1:0] r_chan_base;  // data address of (c, 0, 0)
    logic               r_relu;
    logic               r_dv;         // memory data for an issued tap is on k_data/d_data
    logic [ACC_W-1:0]   r_out_pix;
    logic               r_out_valid;
    logic               r_done;

    logic                    w_accept;
    logic                    w_last;
    logic                    w_finish;
    logic                    w_ack;
    logic signed [ACC_W-1:0] w_acc;

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_c == c_CLAST) && (r_r == c_KLAST) && (r_col == c_KLAST);
    // DRAIN lasts until the final product has landed in the accumulator.
    assign w_finish = (r_state == DRAIN) && !r_dv;
    assign w_ack    = (r_state == HOLD) && out_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start)    w_next_state = FETCH;
            FETCH:   if (w_last)   w_next_state = DRAIN;
            DRAIN:   if (!r_dv)    w_next_state = HOLD;
            HOLD:    if (out_ack)  w_next_state = IDLE;
            default:               w_next_state = IDLE;
        endcase
    end

    // Tap walk: the tap-0 address is loaded on acceptance, then one tap per
    // FETCH cycle. Data addresses step by 1, by a row pitch or by a plane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c         <= '0;
            r_r         <= '0;
            r_col       <= '0;
            r_k_addr    <= '0;
            r_d_addr    <= '0;
            r_row_base  <= '0;
            r_chan_base <= '0;
            r_relu      <= 1'b0;
        end else if (w_accept) begin
            r_c         <= '0;
            r_r         <= '0;
            r_col       <= '0;
            r_k_addr    <= base_addr_k;
            r_d_addr    <= base_addr_d;
            r_row_base  <= base_addr_d;
            r_chan_base <= base_addr_d;
            r_relu      <= relu_en;
        end else if ((r_state == FETCH) && !w_last) begin
            r_k_addr <= r_k_addr + KADDR_W'(1);
            if (r_col != c_KLAST) begin
                r_col    <= r_col + c_KW'(1);
                r_d_addr <= r_d_addr + DADDR_W'(1);
            end else if (r_r != c_KLAST) begin
                r_col      <= '0;
                r_r        <= r_r + c_KW'(1);
                r_d_addr   <= r_row_base + c_ROW;
                r_row_base <= r_row_base + c_ROW;
            end else begin
                r_col       <= '0;
                r_r         <= '0;
                r_c         <= r_c + c_CW'(1);
                r_d_addr    <= r_chan_base + c_PLANE;
                r_row_base  <= r_chan_base + c_PLANE;
                r_chan_base <= r_chan_base + c_PLANE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dv        <= 1'b0;
            r_out_pix   <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_dv   <= (r_state == FETCH);
            r_done <= w_ack;
            if (w_finish) begin
                r_out_valid <= 1'b1;
                r_out_pix   <= (r_relu && w_acc[ACC_W-1]) ? '0 : w_acc;
            end else if (w_ack) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    conv_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SAT    (SAT)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_accept),
        .i_en  (r_dv),
        .i_a   (k_data),
        .i_b   (d_data),
        .o_acc (w_acc)
    );

    assign k_addr    = r_k_addr;
    assign d_addr    = r_d_addr;
    assign out_pix   = r_out_pix;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_conv2d_window_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv2d_window_engine
// Description : Self-checking bench. Two engines (saturating and wrapping)
//               share one stimulus and read identical memories; results are
//               compared against a tap-by-tap arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2d_window_engine;

    localparam int DW  = 8;
    localparam int AW  = 16;
    localparam int KK  = 3;
    localparam int CHN = 2;
    localparam int IW  = 64;
    localparam int IH  = 64;
    localparam int KAW = 10;
    localparam int DAW = 16;
    localparam int NT  = conv_pkg::calc_taps(KK, CHN);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           start = 1'b0;
    logic           relu_en = 1'b0;
    logic           out_ack = 1'b0;
    logic [KAW-1:0] base_k = '0;
    logic [DAW-1:0] base_d = '0;

    logic [KAW-1:0] ka_s, ka_w;
    logic [DAW-1:0] da_s, da_w;
    logic [DW-1:0]  kd_s, dd_s, kd_w, dd_w;
    logic [AW-1:0]  pix_s, pix_w;
    logic           v_s, v_w, busy_s, busy_w, done_s, done_w;

    logic [DW-1:0] kmem [0:(1<<KAW)-1];
    logic [DW-1:0] dmem [0:(1<<DAW)-1];

    always @(posedge clk) begin
        kd_s <= kmem[ka_s];
        dd_s <= dmem[da_s];
        kd_w <= kmem[ka_w];
        dd_w <= dmem[da_w];
    end

    conv2d_window_engine #(
        .DATA_W(DW), .ACC_W(AW), .K(KK), .CH(CHN), .IMG_W(IW), .IMG_H(IH),
        .KADDR_W(KAW), .DADDR_W(DAW), .SAT(1)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .relu_en(relu_en),
        .base_addr_k(base_k), .base_addr_d(base_d), .k_addr(ka_s), .d_addr(da_s),
        .k_data(kd_s), .d_data(dd_s), .out_pix(pix_s), .out_valid(v_s),
        .out_ack(out_ack), .busy(busy_s), .done(done_s)
    );

    conv2d_window_engine #(
        .DATA_W(DW), .ACC_W(AW), .K(KK), .CH(CHN), .IMG_W(IW), .IMG_H(IH),
        .KADDR_W(KAW), .DADDR_W(DAW), .SAT(0)
    ) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .relu_en(relu_en),
        .base_addr_k(base_k), .base_addr_d(base_d), .k_addr(ka_w), .d_addr(da_w),
        .k_data(kd_w), .d_data(dd_w), .out_pix(pix_w), .out_valid(v_w),
        .out_ack(out_ack), .busy(busy_w), .done(done_w)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic int kaddr_of(input int t, input int kb);
        int c, r, col;
        c = t / (KK * KK); r = (t / KK) % KK; col = t % KK;
        return (kb + c * KK * KK + r * KK + col) % (1 << KAW);
    endfunction

    function automatic int daddr_of(input int t, input int db);
        int c, r, col;
        c = t / (KK * KK); r = (t / KK) % KK; col = t % KK;
        return (db + c * IW * IH + r * IW + col) % (1 << DAW);
    endfunction

    function automatic longint model(input int kb, input int db, input bit relu, input bit sat);
        longint acc, p, mx, mn;
        logic signed [AW-1:0] w;
        acc = 0;
        mx = (64'sd1 <<< (AW - 1)) - 1;
        mn = -(64'sd1 <<< (AW - 1));
        for (int t = 0; t < NT; t++) begin
            p = longint'($signed(kmem[kaddr_of(t, kb)])) * longint'($signed(dmem[daddr_of(t, db)]));
            acc = acc + p;
            if (sat) begin
                if (acc > mx) acc = mx;
                if (acc < mn) acc = mn;
            end else begin
                w = AW'(acc);
                acc = longint'(w);
            end
        end
        if (relu && acc < 0) acc = 0;
        return acc;
    endfunction

    // mode 0: random everywhere; 1: uniform kval/dval on all taps;
    // 2: channel 0 weight kval with pixel dval (or t+1 when dval<0), channel 1 weight 0
    task automatic fill(input int kb, input int db, input int mode, input int kval, input int dval);
        for (int t = 0; t < NT; t++) begin
            case (mode)
                0: begin
                    kmem[kaddr_of(t, kb)] = DW'($urandom);
                    dmem[daddr_of(t, db)] = DW'($urandom);
                end
                1: begin
                    kmem[kaddr_of(t, kb)] = DW'(kval);
                    dmem[daddr_of(t, db)] = DW'(dval);
                end
                default: begin
                    if (t < KK * KK) begin
                        kmem[kaddr_of(t, kb)] = DW'(kval);
                        dmem[daddr_of(t, db)] = (dval < 0) ? DW'(t + 1) : DW'(dval);
                    end else begin
                        kmem[kaddr_of(t, kb)] = '0;
                        dmem[daddr_of(t, db)] = DW'($urandom);
                    end
                end
            endcase
        end
    endtask

    task automatic run_window(input int kb, input int db, input bit relu, input int hold,
                              input bit ack_with_start, output longint got_s, output longint got_w);
        longint es, ew;
        int lat;
        es = model(kb, db, relu, 1'b1);
        ew = model(kb, db, relu, 1'b0);
        @(negedge clk);
        start = 1'b1; base_k = KAW'(kb); base_d = DAW'(db); relu_en = relu;
        @(negedge clk);
        // Scramble the request inputs to show they were captured with start.
        start = 1'b0; base_k = KAW'($urandom); base_d = DAW'($urandom); relu_en = 1'($urandom);
        for (int t = 0; t < NT; t++) begin
            chk("k_addr", longint'(ka_s), longint'(kaddr_of(t, kb)));
            chk("d_addr", longint'(da_s), longint'(daddr_of(t, db)));
            chk("d_addr_wrapdut", longint'(da_w), longint'(daddr_of(t, db)));
            @(negedge clk);
        end
        lat = NT;
        while (!v_s && lat < NT + 8) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", longint'(lat), longint'(NT + 2));
        chk("valid_wrapdut", longint'(v_w), 1);
        chk("pix_sat", longint'($signed(pix_s)), es);
        chk("pix_wrap", longint'($signed(pix_w)), ew);
        got_s = longint'($signed(pix_s));
        got_w = longint'($signed(pix_w));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", longint'(v_s), 1);
            chk("hold_pix", longint'($signed(pix_s)), es);
            chk("hold_done", longint'(done_s), 0);
        end
        out_ack = 1'b1;
        start = ack_with_start;
        @(negedge clk);
        out_ack = 1'b0;
        start = 1'b0;
        chk("valid_fall", longint'(v_s), 0);
        chk("done_pulse", longint'(done_s), 1);
        chk("done_pulse_wrapdut", longint'(done_w), 1);
        chk("busy_fall", longint'(busy_s), 0);
        @(negedge clk);
        chk("done_single", longint'(done_s), 0);
        chk("no_queued_start", longint'(busy_s), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_k_addr"}, longint'(ka_s), 0);
        chk({tag, "_d_addr"}, longint'(da_s), 0);
        chk({tag, "_out_pix"}, longint'(pix_s), 0);
        chk({tag, "_out_valid"}, longint'(v_s), 0);
        chk({tag, "_busy"}, longint'(busy_s), 0);
        chk({tag, "_done"}, longint'(done_s), 0);
        chk({tag, "_wrapdut_pix"}, longint'(pix_w), 0);
    endtask

    initial begin
        longint gs, gw;
        int kb, db;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Pin the address model against hand-computed values.
        chk("model_daddr_tap1", longint'(daddr_of(1, 'h100)), 'h101);
        chk("model_daddr_tap3", longint'(daddr_of(3, 'h100)), 'h140);
        chk("model_daddr_tap9", longint'(daddr_of(9, 'h100)), 'h1100);

        // Ones kernel over pixels 1..9 (channel 1 weights zero).
        fill(0, 'h100, 2, 1, -1);
        run_window(0, 'h100, 1'b0, 0, 1'b0, gs, gw);
        chk("ones_1to9_sat", gs, 45);
        chk("ones_1to9_wrap", gw, 45);

        // Most-negative operands everywhere: 18 * 16384 = 294912.
        fill(5, 'h2000, 1, -128, -128);
        run_window(5, 'h2000, 1'b0, 1, 1'b0, gs, gw);
        chk("saturate_max", gs, 32767);
        chk("wrap_value", gw, -32768);

        // Weights -1, pixels 5: ReLU on, long hold, ack together with start.
        fill(100, 'h3000, 2, -1, 5);
        run_window(100, 'h3000, 1'b1, 20, 1'b1, gs, gw);
        chk("relu_clamp", gs, 0);
        run_window(100, 'h3000, 1'b0, 2, 1'b0, gs, gw);
        chk("relu_off", gs, -45);

        // Randomized windows, including data addresses that wrap.
        repeat (8) begin
            kb = int'($urandom_range(0, (1 << KAW) - 1));
            db = int'($urandom_range(0, (1 << DAW) - 1));
            fill(kb, db, 0, 0, 0);
            run_window(kb, db, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom), gs, gw);
        end

        // Reset while the fifth tap address is presented.
        kb = 17; db = 'h0450;
        fill(kb, db, 0, 0, 0);
        @(negedge clk);
        start = 1'b1; base_k = KAW'(kb); base_d = DAW'(db); relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("tap4_addr", longint'(ka_s), longint'(kaddr_of(4, kb)));
        chk("tap4_busy", longint'(busy_s), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_window(kb, db, 1'b0, 0, 1'b0, gs, gw);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
